// File: rtl/mole_pkg.sv
// Shared types and defaults for the whack-a-mole round sequencer.
package mole_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SHOW = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int N_MOLES     = 4;
    localparam int IDX_W       = 2;
    localparam int TIMER_W     = 16;
    localparam int SHOW_MS_DEF = 750;
    localparam int GAP_MS_DEF  = 250;
    localparam int ROUNDS_DEF  = 20;
    localparam int SCORE_W_DEF = 8;

    function automatic logic [N_MOLES-1:0] mole_onehot(input logic [IDX_W-1:0] idx);
        logic [N_MOLES-1:0] base;
        base = 4'b0001;
        mole_onehot = base << idx;
    endfunction

    // Never show the same mole twice in a row: bump to the next one on a repeat.
    function automatic logic [IDX_W-1:0] pick_mole(input logic [IDX_W-1:0] rnd,
                                                   input logic [IDX_W-1:0] prev);
        if (rnd == prev) begin
            pick_mole = rnd + 2'd1;
        end else begin
            pick_mole = rnd;
        end
    endfunction

endpackage

// File: rtl/mole_round_ctrl_if.sv
// Game-side signal bundle of the round sequencer; master drives stimulus, slave is the sequencer.
interface mole_round_ctrl_if #(
    parameter int SCORE_W = 8
);
    logic               tick_ms;
    logic               start;
    logic [3:0]         rand_in;
    logic [3:0]         button;
    logic [3:0]         mole_out;
    logic [SCORE_W-1:0] score;
    logic [7:0]         rounds_left;
    logic               hit_pulse;
    logic               miss_pulse;
    logic               game_over;
    logic               busy;

    modport master (
        output tick_ms, start, rand_in, button,
        input  mole_out, score, rounds_left, hit_pulse, miss_pulse, game_over, busy
    );

    modport slave (
        input  tick_ms, start, rand_in, button,
        output mole_out, score, rounds_left, hit_pulse, miss_pulse, game_over, busy
    );
endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer per button followed by a rising-edge detector.
module btn_sync_edge #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_edge
);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] prev_r;

    // Synchronizer chain plus the one-cycle-delayed copy used for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= {WIDTH{1'b0}};
            sync2_r <= {WIDTH{1'b0}};
            prev_r  <= {WIDTH{1'b0}};
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign btn_edge = sync2_r & ~prev_r;

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: picks a mole per round, times the window, judges presses, keeps score.
module mole_round_ctrl
    import mole_pkg::*;
#(
    parameter int SHOW_MS = SHOW_MS_DEF,
    parameter int GAP_MS  = GAP_MS_DEF,
    parameter int ROUNDS  = ROUNDS_DEF,
    parameter int SCORE_W = SCORE_W_DEF
) (
    input logic            clk,
    input logic            reset,
    mole_round_ctrl_if.slave bus
);

    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_MS - 1);
    localparam logic [TIMER_W-1:0] SHOW_LAST = TIMER_W'(SHOW_MS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
    localparam logic [7:0]         ROUNDS_INIT = 8'(ROUNDS);

    state_t               state_r,      state_nxt_s;
    logic [TIMER_W-1:0]   timer_r,      timer_nxt_s;
    logic [SCORE_W-1:0]   score_r,      score_nxt_s;
    logic [7:0]           rounds_r,     rounds_nxt_s;
    logic [IDX_W-1:0]     prev_idx_r,   prev_idx_nxt_s;
    logic [N_MOLES-1:0]   mole_out_r,   mole_out_nxt_s;
    logic                 hit_r,        hit_nxt_s;
    logic                 miss_r,       miss_nxt_s;
    logic                 game_over_r,  game_over_nxt_s;
    logic                 busy_r,       busy_nxt_s;
    logic [N_MOLES-1:0]   btn_edge_s;
    logic [N_MOLES-1:0]   lit_mask_s;
    logic                 lit_edge_s;
    logic                 wrong_edge_s;

    btn_sync_edge #(
        .WIDTH (N_MOLES)
    ) u_btn_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (bus.button),
        .btn_edge (btn_edge_s)
    );

    assign lit_mask_s   = mole_onehot(prev_idx_r);
    assign lit_edge_s   = |(btn_edge_s & lit_mask_s);
    assign wrong_edge_s = |(btn_edge_s & ~lit_mask_s);

    // Next-state, counters and registered-output values.
    always_comb begin
        state_nxt_s    = state_r;
        timer_nxt_s    = timer_r;
        score_nxt_s    = score_r;
        rounds_nxt_s   = rounds_r;
        prev_idx_nxt_s = prev_idx_r;
        hit_nxt_s      = 1'b0;
        miss_nxt_s     = 1'b0;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_nxt_s  = ST_GAP;
                    rounds_nxt_s = ROUNDS_INIT;
                    score_nxt_s  = {SCORE_W{1'b0}};
                    timer_nxt_s  = {TIMER_W{1'b0}};
                end else begin
                    state_nxt_s  = state_r;
                end
            end
            ST_GAP: begin
                if (bus.tick_ms) begin
                    if (timer_r == GAP_LAST) begin
                        timer_nxt_s = {TIMER_W{1'b0}};
                        if (rounds_r == 8'd0) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            prev_idx_nxt_s = pick_mole(bus.rand_in[1:0], prev_idx_r);
                            rounds_nxt_s   = rounds_r - 8'd1;
                            state_nxt_s    = ST_SHOW;
                        end
                    end else begin
                        timer_nxt_s = timer_r + 16'd1;
                    end
                end else begin
                    timer_nxt_s = timer_r;
                end
            end
            ST_SHOW: begin
                // A hit on the lit button outranks any wrong press or timeout in the same cycle.
                if (lit_edge_s) begin
                    hit_nxt_s   = 1'b1;
                    timer_nxt_s = {TIMER_W{1'b0}};
                    state_nxt_s = ST_GAP;
                    if (score_r != SCORE_MAX) begin
                        score_nxt_s = score_r + SCORE_ONE;
                    end else begin
                        score_nxt_s = score_r;
                    end
                end else begin
                    if (wrong_edge_s) begin
                        miss_nxt_s = 1'b1;
                        if (score_r != {SCORE_W{1'b0}}) begin
                            score_nxt_s = score_r - SCORE_ONE;
                        end else begin
                            score_nxt_s = score_r;
                        end
                    end else begin
                        score_nxt_s = score_r;
                    end
                    if (bus.tick_ms) begin
                        if (timer_r == SHOW_LAST) begin
                            miss_nxt_s  = 1'b1;
                            timer_nxt_s = {TIMER_W{1'b0}};
                            state_nxt_s = ST_GAP;
                        end else begin
                            timer_nxt_s = timer_r + 16'd1;
                        end
                    end else begin
                        timer_nxt_s = timer_r;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        mole_out_nxt_s  = (state_nxt_s == ST_SHOW) ? mole_onehot(prev_idx_nxt_s) : 4'b0000;
        game_over_nxt_s = (state_nxt_s == ST_DONE);
        busy_nxt_s      = (state_nxt_s == ST_GAP) || (state_nxt_s == ST_SHOW);
    end

    // State, counters and output registers; reset aborts any round silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            timer_r     <= {TIMER_W{1'b0}};
            score_r     <= {SCORE_W{1'b0}};
            rounds_r    <= 8'd0;
            prev_idx_r  <= {IDX_W{1'b0}};
            mole_out_r  <= 4'b0000;
            hit_r       <= 1'b0;
            miss_r      <= 1'b0;
            game_over_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            timer_r     <= timer_nxt_s;
            score_r     <= score_nxt_s;
            rounds_r    <= rounds_nxt_s;
            prev_idx_r  <= prev_idx_nxt_s;
            mole_out_r  <= mole_out_nxt_s;
            hit_r       <= hit_nxt_s;
            miss_r      <= miss_nxt_s;
            game_over_r <= game_over_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign bus.mole_out    = mole_out_r;
    assign bus.score       = score_r;
    assign bus.rounds_left = rounds_r;
    assign bus.hit_pulse   = hit_r;
    assign bus.miss_pulse  = miss_r;
    assign bus.game_over   = game_over_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Bench for mole_round_ctrl: directed game script with literal checks, then random play against a game model.
module tb_mole_round_ctrl;

    localparam int SHOW_MS = 3;
    localparam int GAP_MS  = 2;
    localparam int ROUNDS  = 6;
    localparam int SCORE_W = 2;
    localparam int SMAX    = (1 << SCORE_W) - 1;

    localparam int P_IDLE = 0;
    localparam int P_GAP  = 1;
    localparam int P_SHOW = 2;
    localparam int P_DONE = 3;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mole_round_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

    mole_round_ctrl #(
        .SHOW_MS (SHOW_MS),
        .GAP_MS  (GAP_MS),
        .ROUNDS  (ROUNDS),
        .SCORE_W (SCORE_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Game model state: phase, window timer, score, rounds, last shown mole, raw button history.
    int         m_phase, m_timer, m_score, m_rounds, m_prev;
    bit         m_hit, m_miss;
    logic [3:0] h1, h2, h3;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] e;
        int idx;
        m_hit  = 1'b0;
        m_miss = 1'b0;
        if (reset) begin
            m_phase = P_IDLE; m_timer = 0; m_score = 0; m_rounds = 0; m_prev = 0;
            h1 = 4'd0; h2 = 4'd0; h3 = 4'd0;
        end else begin
            // A press is seen once its sample is two cycles old and the sample before it was low.
            e  = h2 & ~h3;
            h3 = h2; h2 = h1; h1 = bus.button;
            case (m_phase)
                P_IDLE, P_DONE: begin
                    if (bus.start) begin
                        m_phase = P_GAP; m_rounds = ROUNDS; m_score = 0; m_timer = 0;
                    end
                end
                P_GAP: begin
                    if (bus.tick_ms) begin
                        if (m_timer == GAP_MS - 1) begin
                            m_timer = 0;
                            if (m_rounds == 0) begin
                                m_phase = P_DONE;
                            end else begin
                                idx = int'(bus.rand_in) % 4;
                                if (idx == m_prev) idx = (idx + 1) % 4;
                                m_prev = idx;
                                m_rounds--;
                                m_phase = P_SHOW;
                            end
                        end else begin
                            m_timer++;
                        end
                    end
                end
                P_SHOW: begin
                    if (e[m_prev]) begin
                        m_hit = 1'b1;
                        if (m_score < SMAX) m_score++;
                        m_timer = 0;
                        m_phase = P_GAP;
                    end else begin
                        if (e != 4'd0) begin
                            m_miss = 1'b1;
                            if (m_score > 0) m_score--;
                        end
                        if (bus.tick_ms) begin
                            if (m_timer == SHOW_MS - 1) begin
                                m_miss = 1'b1; m_timer = 0; m_phase = P_GAP;
                            end else begin
                                m_timer++;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        chk("mole_out",    32'(bus.mole_out),    (m_phase == P_SHOW) ? (1 << m_prev) : 0);
        chk("score",       32'(bus.score),       m_score);
        chk("rounds_left", 32'(bus.rounds_left), m_rounds);
        chk("hit_pulse",   32'(bus.hit_pulse),   int'(m_hit));
        chk("miss_pulse",  32'(bus.miss_pulse),  int'(m_miss));
        chk("game_over",   32'(bus.game_over),   (m_phase == P_DONE) ? 1 : 0);
        chk("busy",        32'(bus.busy),        (m_phase == P_GAP || m_phase == P_SHOW) ? 1 : 0);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_ms = 1'b1; step();
            bus.tick_ms = 1'b0; step();
        end
    endtask

    task automatic press_hold(input logic [3:0] mask);
        bus.button = mask;
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic release_btn();
        bus.button = 4'd0;
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1;
        bus.tick_ms = 1'b0; bus.start = 1'b0; bus.rand_in = 4'd0; bus.button = 4'd0;
        @(negedge clk);
        step(); step();
        chk("lit_reset_busy", 32'(bus.busy), 0);
        reset = 1'b0;
        step();

        bus.start = 1'b1; step(); bus.start = 1'b0;
        bus.rand_in = 4'd2;
        tick_n(2);
        chk("lit_first_mole",   32'(bus.mole_out),    4'b0100);
        chk("lit_first_rounds", 32'(bus.rounds_left), ROUNDS - 1);

        press_hold(4'b0100);
        chk("lit_hit_pulse", 32'(bus.hit_pulse), 1);
        chk("lit_hit_score", 32'(bus.score),     1);
        chk("lit_hit_dark",  32'(bus.mole_out),  0);
        release_btn();

        tick_n(2);
        chk("lit_norepeat_mole", 32'(bus.mole_out), 4'b1000);
        press_hold(4'b0001);
        chk("lit_wrong_miss",  32'(bus.miss_pulse), 1);
        chk("lit_wrong_score", 32'(bus.score),      0);
        chk("lit_wrong_lit",   32'(bus.mole_out),   4'b1000);
        release_btn();
        press_hold(4'b0001);
        chk("lit_wrong_sat0", 32'(bus.score), 0);
        release_btn();
        tick_n(2);
        bus.tick_ms = 1'b1; step();
        chk("lit_timeout_miss", 32'(bus.miss_pulse), 1);
        chk("lit_timeout_dark", 32'(bus.mole_out),   0);
        bus.tick_ms = 1'b0; step();

        bus.rand_in = 4'd1;
        tick_n(2);
        chk("lit_rand1_a", 32'(bus.mole_out), 4'b0010);
        press_hold(4'b0010); release_btn();
        tick_n(2);
        chk("lit_rand1_b", 32'(bus.mole_out),    4'b0100);
        chk("lit_rounds2", 32'(bus.rounds_left), 2);
        press_hold(4'b1100);
        chk("lit_dual_hit",   32'(bus.hit_pulse),  1);
        chk("lit_dual_nomis", 32'(bus.miss_pulse), 0);
        chk("lit_dual_score", 32'(bus.score),      2);
        release_btn();

        bus.rand_in = 4'd0;
        tick_n(2);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("lit_busy_start_rounds", 32'(bus.rounds_left), 1);
        press_hold(4'b0001); release_btn();
        tick_n(2);
        press_hold(4'b0010);
        chk("lit_score_sat", 32'(bus.score), 3);
        release_btn();
        tick_n(2);
        chk("lit_game_over", 32'(bus.game_over), 1);
        chk("lit_done_busy", 32'(bus.busy),      0);
        chk("lit_done_score", 32'(bus.score),    3);

        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("lit_restart_score",  32'(bus.score),       0);
        chk("lit_restart_rounds", 32'(bus.rounds_left), ROUNDS);
        tick_n(2);
        reset = 1'b1; step();
        chk("lit_abort_mole", 32'(bus.mole_out), 0);
        chk("lit_abort_busy", 32'(bus.busy),     0);
        reset = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom_range(0, 499) == 0);
            bus.start   = ($urandom_range(0, 29) == 0);
            bus.tick_ms = ($urandom_range(0, 2) == 0);
            bus.rand_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) bus.button = 4'($urandom_range(0, 15));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mole_round_ctrl.md
Name: mole_round_ctrl

Overview:
- Game sequencer for the whack-a-mole datapath.
- Samples the pseudo-random pattern source once per round, lights exactly one mole LED for a timed window, and judges button presses as hit, wrong or miss.
- Keeps the saturating score and the round count, and raises game_over at the end of a game.
- Sits between the LFSR/pattern generator, the push buttons and the score/seven-segment display path.
- Uses only the main clk plus a 1 ms tick enable; it has no derived clocks.

Parameters:
- N_MOLES, 4: number of mole LEDs and buttons. Fixed at 4 for this revision.
- SHOW_MS, 750: mole visible window, in tick_ms pulses.
- GAP_MS, 250: dark interval between moles, in tick_ms pulses.
- ROUNDS, 20: moles per game, range 1..255.
- SCORE_W, 8: score width in bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- tick_ms  in  1  one-clk-wide 1 ms enable pulse.
- start  in  1  level, acted on only in IDLE or DONE.
- rand_in  in  4  pattern source value, sampled on GAP->SHOW.
- button  in  4  raw asynchronous push buttons.
- mole_out  out  4  one-hot lit mole, or 0.
- score  out  SCORE_W  current score.
- rounds_left  out  8  moles remaining in the game.
- hit_pulse  out  1  1-clk pulse on a hit.
- miss_pulse  out  1  1-clk pulse on timeout or wrong press.
- game_over  out  1  high in DONE.
- busy  out  1  high in GAP or SHOW.

Behaviour:
- Reset, synchronous, active-high:
  - state=IDLE; mole_out=0; score=0; rounds_left=0.
  - Pulses=0; game_over=0; busy=0; timer=0; prev_idx=0; sync/edge flops=0.
  - Reset mid-game aborts the round with no pulses.
- Button path:
  - 2-flop synchronizer per bit, then rising-edge detect.
  - An edge counts in the clk after the second flop rises, i.e. 3 clk after a raw rise.
  - Edges are ignored outside SHOW.
- FSM states:
  - IDLE: start=1 -> rounds_left=ROUNDS, score=0, timer=0, go to GAP.
  - GAP: mole_out=0; timer++ on tick_ms. When timer reaches GAP_MS-1 on a tick:
    - rounds_left==0 -> DONE.
    - otherwise pick the mole, rounds_left--, timer=0, go to SHOW.
  - SHOW: mole_out=onehot(idx); timer++ on tick_ms.
    - Edge on the lit button -> hit_pulse, score+1 saturating at 2^SCORE_W-1, timer=0, go to GAP.
    - Edge only on unlit button(s) -> miss_pulse, score-1 saturating at 0, stay in SHOW, timer not reset.
    - Timer reaches SHOW_MS-1 on a tick with no hit -> miss_pulse, timer=0, go to GAP. Score is unchanged.
  - DONE: game_over=1; score and mole_out=0 are held. start=1 -> behaves as IDLE start (new game, score cleared).
- Mole pick:
  - idx = rand_in[1:0].
  - If idx==prev_idx, use idx+1 mod 4, so there are no repeats.
  - prev_idx is updated with the idx actually shown.
- Simultaneous events in one clk:
  - Hit has priority over wrong and over timeout: one hit_pulse only, no miss_pulse.
  - Several unlit edges in one clk count as one wrong press (one decrement).
- start while busy is ignored.
- Latency: mole_out changes in the clk after the deciding tick or edge; pulses are registered and coincide with the state change.
- All outputs are registered.

Decomposition:
- Shared package mole_pkg: state encoding (IDLE=0, GAP=1, SHOW=2, DONE=3), N_MOLES, and the default timing constants.
- Sub-module btn_sync_edge: per-bit 2-flop synchronizer plus rising-edge detector, parameterized on width, output a 1-clk edge vector.
- The FSM, timer, score and round counter stay in mole_round_ctrl.

Test Plan:
- Reset, then start pulse with ROUNDS=2, GAP_MS=2, SHOW_MS=3 and rand_in=2 -> after 2 ticks, mole_out=4'b0100 and rounds_left=1.
- In SHOW with mole 2 lit, raise button[2] -> hit_pulse 3 clk later, score=1, mole_out=0, state GAP.
- In SHOW, raise button[0] -> miss_pulse and score stays 0 (saturation at 0). Mole stays lit; timeout after the remaining ticks gives a second miss_pulse.
- rand_in held at 1 for two rounds -> moles shown are 4'b0010 then 4'b0100. After the last round plus GAP, game_over=1 and busy=0.
- Same-clk edges on button[2] (lit) and button[3] -> single hit_pulse, no miss_pulse, score+1. Also: score preset near max via repeated hits at SCORE_W=2 -> score holds at 3.
- Assert reset during SHOW -> next clk mole_out=0, score=0, state IDLE, no pulses. start during SHOW is ignored (rounds_left unchanged).
